ahb_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the AHB-to-APB bridge's single AHB slave port between up to four AHB masters. It sits between the masters and the bridge. It selects an owner and muxes the owner's address-phase signals to the bridge. It tracks the pipelined data phase so that Hwdata follows the previous owner, and it enforces a beat budget per tenure so that one master cannot starve the others.

---
 rtl/bridge_pkg.sv | 31 +++
 rtl/ahb_bus_arbiter_rr_pick.sv | 29 ++
 rtl/ahb_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB bus arbiter.
// Optional build macro: AHB_ARB_LOCK_EN adds the ARB_LOCKED state.
package bridge_pkg;

    localparam int MASTER_IDX_W = 2;
    localparam int MAX_M        = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWNED
`ifdef AHB_ARB_LOCK_EN
        , ARB_LOCKED
`endif
    } arb_state_t;

    // Round-robin pointer successor, wrapping at n.
    function automatic logic [MASTER_IDX_W-1:0] rr_next(
        input logic [MASTER_IDX_W-1:0] idx,
        input int n
    );
        if (int'(idx) + 1 >= n)
            return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Returns the winning index and whether any request was found.
module rr_pick
    import bridge_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]            req,
    input  logic [MASTER_IDX_W-1:0] ptr,
    output logic [MASTER_IDX_W-1:0] idx,
    output logic                    found
);

    // Scan from ptr upward with wrap, keep the first hit.
    always_comb begin
        int j;
        j     = 0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                idx   = MASTER_IDX_W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter sharing one bridge slave port among masters.
// Optional build macro: AHB_ARB_LOCK_EN enables Hlock and ARB_LOCKED.
module ahb_bus_arbiter
    import bridge_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_BEATS   = 8,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                          Hclk,
    input  logic                          Hresetn,
    input  logic [NUM_MASTERS-1:0]        Hbusreq,
`ifdef AHB_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]        Hlock,
`endif
    input  logic [2*NUM_MASTERS-1:0]      Htrans_m,
    input  logic [ADDR_W*NUM_MASTERS-1:0] Haddr_m,
    input  logic [NUM_MASTERS-1:0]        Hwrite_m,
    input  logic [DATA_W*NUM_MASTERS-1:0] Hwdata_m,
    input  logic                          Hreadyout,
    output logic [NUM_MASTERS-1:0]        Hgrant,
    output logic [MASTER_IDX_W-1:0]       Hmaster,
    output logic [1:0]                    Htrans,
    output logic [ADDR_W-1:0]             Haddr,
    output logic                          Hwrite,
    output logic [DATA_W-1:0]             Hwdata,
    output logic                          Hreadyin
);

    logic [1:0]        trans_a [MAX_M];
    logic [ADDR_W-1:0] addr_a  [MAX_M];
    logic [DATA_W-1:0] wdata_a [MAX_M];
    logic [MAX_M-1:0]  req4;
    logic [MAX_M-1:0]  wr4;
    logic [MAX_M-1:0]  lock4;

    arb_state_t              state, n_state;
    logic [MASTER_IDX_W-1:0] owner, n_owner;
    logic [MASTER_IDX_W-1:0] data_owner, n_data_owner;
    logic [MASTER_IDX_W-1:0] rr_ptr, n_rr;
    logic [7:0]              beat_cnt, n_beat;
    logic                    data_act, n_data_act;

    logic [MASTER_IDX_W-1:0] pick_idx;
    logic                    pick_found;
    logic [1:0]              own_trans;
    logic [MAX_M-1:0]        own_oh;
    logic                    boundary;
    logic                    at_max;
    logic                    others;
    logic                    rearb;
    logic                    lock_hold;
    logic [7:0]              beat_inc;
    logic                    idle;

    // Unpack flat per-master buses into fixed 4-entry tables.
    for (genvar g = 0; g < MAX_M; g++) begin : g_m
        if (g < NUM_MASTERS) begin : g_on
            assign trans_a[g] = Htrans_m[2*g +: 2];
            assign addr_a[g]  = Haddr_m[ADDR_W*g +: ADDR_W];
            assign wdata_a[g] = Hwdata_m[DATA_W*g +: DATA_W];
            assign req4[g]    = Hbusreq[g];
            assign wr4[g]     = Hwrite_m[g];
`ifdef AHB_ARB_LOCK_EN
            assign lock4[g]   = Hlock[g];
`else
            assign lock4[g]   = 1'b0;
`endif
        end else begin : g_off
            assign trans_a[g] = HTRANS_IDLE;
            assign addr_a[g]  = '0;
            assign wdata_a[g] = '0;
            assign req4[g]    = 1'b0;
            assign wr4[g]     = 1'b0;
            assign lock4[g]   = 1'b0;
        end
    end

    rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req   (Hbusreq),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign own_trans = trans_a[owner];
    assign own_oh    = MAX_M'(1) << owner;
    assign boundary  = (own_trans == HTRANS_IDLE) ||
                       (own_trans == HTRANS_NONSEQ);
    assign at_max    = (beat_cnt == 8'(MAX_BEATS));
    assign others    = |(req4 & ~own_oh);
    assign rearb     = boundary && (!req4[owner] || (at_max && others));
    assign beat_inc  = (own_trans[1] && !at_max) ? beat_cnt + 8'd1
                                                 : beat_cnt;
    assign idle      = (state == ARB_IDLE);

    // Owner state register set; everything frozen outside arb points.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            data_owner <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            data_act   <= 1'b0;
        end else begin
            state      <= n_state;
            owner      <= n_owner;
            data_owner <= n_data_owner;
            rr_ptr     <= n_rr;
            beat_cnt   <= n_beat;
            data_act   <= n_data_act;
        end
    end

    // Next owner, tenure and data-phase tracking.
    always_comb begin
        n_state      = state;
        n_owner      = owner;
        n_data_owner = data_owner;
        n_rr         = rr_ptr;
        n_beat       = beat_cnt;
        n_data_act   = data_act;
        lock_hold    = 1'b0;
`ifdef AHB_ARB_LOCK_EN
        lock_hold = lock4[owner] ||
                    ((state == ARB_LOCKED) && !boundary);
`endif
        if (Hreadyout) begin
            n_data_owner = owner;
            n_data_act   = !idle;
            if (idle) begin
                if (pick_found) begin
                    n_state = ARB_OWNED;
                    n_owner = pick_idx;
                    n_rr    = rr_next(pick_idx, NUM_MASTERS);
                    n_beat  = '0;
                end
            end else if (lock_hold) begin
`ifdef AHB_ARB_LOCK_EN
                n_state = ARB_LOCKED;
`endif
                n_beat = beat_inc;
            end else if (rearb) begin
                n_beat = '0;
                if (pick_found) begin
                    n_state = ARB_OWNED;
                    n_owner = pick_idx;
                    n_rr    = rr_next(pick_idx, NUM_MASTERS);
                end else begin
                    n_state = ARB_IDLE;
                end
            end else begin
                n_state = ARB_OWNED;
                n_beat  = beat_inc;
            end
        end
    end

    // Bridge-side muxes; address phase gated off while unowned.
    always_comb begin
        Hgrant   = idle ? '0 : own_oh[NUM_MASTERS-1:0];
        Hmaster  = owner;
        Htrans   = idle ? HTRANS_IDLE : own_trans;
        Haddr    = idle ? '0 : addr_a[owner];
        Hwrite   = !idle && wr4[owner];
        Hwdata   = data_act ? wdata_a[data_owner] : '0;
        Hreadyin = Hreadyout;
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (2 masters, MAX_BEATS=4).
// Lock scenario is built only with AHB_ARB_LOCK_EN.
module tb_ahb_bus_arbiter;

    localparam int NM = 2;
    localparam int MB = 4;

    logic          Hclk;
    logic          Hresetn;
    logic [NM-1:0] Hbusreq;
`ifdef AHB_ARB_LOCK_EN
    logic [NM-1:0] Hlock;
`endif
    logic [2*NM-1:0]  Htrans_m;
    logic [32*NM-1:0] Haddr_m;
    logic [NM-1:0]    Hwrite_m;
    logic [32*NM-1:0] Hwdata_m;
    logic             Hreadyout;
    logic [NM-1:0]    Hgrant;
    logic [1:0]       Hmaster;
    logic [1:0]       Htrans;
    logic [31:0]      Haddr;
    logic             Hwrite;
    logic [31:0]      Hwdata;
    logic             Hreadyin;

    int ncmp = 0;
    int nerr = 0;

    ahb_bus_arbiter #(
        .NUM_MASTERS (NM),
        .MAX_BEATS   (MB),
        .ADDR_W      (32),
        .DATA_W      (32)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hbusreq   (Hbusreq),
`ifdef AHB_ARB_LOCK_EN
        .Hlock     (Hlock),
`endif
        .Htrans_m  (Htrans_m),
        .Haddr_m   (Haddr_m),
        .Hwrite_m  (Hwrite_m),
        .Hwdata_m  (Hwdata_m),
        .Hreadyout (Hreadyout),
        .Hgrant    (Hgrant),
        .Hmaster   (Hmaster),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwrite    (Hwrite),
        .Hwdata    (Hwdata),
        .Hreadyin  (Hreadyin)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int i, input logic [1:0] t,
                       input logic [31:0] a, input logic w,
                       input logic [31:0] d);
        Htrans_m[2*i +: 2]  = t;
        Haddr_m[32*i +: 32] = a;
        Hwrite_m[i]         = w;
        Hwdata_m[32*i +: 32] = d;
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse();
        Hresetn   = 1'b0;
        Hbusreq   = '0;
        Htrans_m  = '0;
        Haddr_m   = '0;
        Hwrite_m  = '0;
        Hwdata_m  = '0;
        Hreadyout = 1'b1;
`ifdef AHB_ARB_LOCK_EN
        Hlock     = '0;
`endif
        #2;
        Hresetn = 1'b1;
    endtask

    initial begin
        // Reset state with master 0 driving junk
        Hresetn   = 1'b0;
        Hbusreq   = '0;
        Htrans_m  = '0;
        Haddr_m   = '0;
        Hwrite_m  = '0;
        Hwdata_m  = '0;
        Hreadyout = 1'b1;
`ifdef AHB_ARB_LOCK_EN
        Hlock     = '0;
`endif
        drv(0, 2'b10, 32'h1234, 1'b1, 32'h5678);
        #2;
        chk("rst_grant", 32'(Hgrant), 32'h0);
        chk("rst_master", 32'(Hmaster), 32'h0);
        chk("rst_trans", 32'(Htrans), 32'h0);
        chk("rst_addr", Haddr, 32'h0);
        chk("rst_write", 32'(Hwrite), 32'h0);
        chk("rst_wdata", Hwdata, 32'h0);
        chk("rst_readyin1", 32'(Hreadyin), 32'h1);
        Hreadyout = 1'b0;
        #1;
        chk("rst_readyin0", 32'(Hreadyin), 32'h0);
        Hreadyout = 1'b1;
        tick();
        chk("rst_hold_grant", 32'(Hgrant), 32'h0);
        rst_pulse();

        // Test 1: 4-beat write burst from master 0
        Hbusreq = 2'b01;
        tick();
        drv(0, 2'b10, 32'h10, 1'b1, 32'h0);
        #1;
        chk("t1_grant", 32'(Hgrant), 32'h1);
        chk("t1_trans0", 32'(Htrans), 32'h2);
        chk("t1_addr0", Haddr, 32'h10);
        chk("t1_write", 32'(Hwrite), 32'h1);
        chk("t1_wdata_none", Hwdata, 32'h0);
        tick();
        drv(0, 2'b11, 32'h14, 1'b1, 32'hD0);
        #1;
        chk("t1_trans1", 32'(Htrans), 32'h3);
        chk("t1_addr1", Haddr, 32'h14);
        chk("t1_wdata0", Hwdata, 32'hD0);
        tick();
        drv(0, 2'b11, 32'h18, 1'b1, 32'hD1);
        #1;
        chk("t1_addr2", Haddr, 32'h18);
        chk("t1_wdata1", Hwdata, 32'hD1);
        tick();
        drv(0, 2'b11, 32'h1C, 1'b1, 32'hD2);
        #1;
        chk("t1_addr3", Haddr, 32'h1C);
        chk("t1_wdata2", Hwdata, 32'hD2);
        tick();
        Hbusreq = 2'b00;
        drv(0, 2'b00, 32'h0, 1'b0, 32'hD3);
        #1;
        chk("t1_grant_last", 32'(Hgrant), 32'h1);
        chk("t1_wdata3", Hwdata, 32'hD3);
        tick();
        chk("t1_release", 32'(Hgrant), 32'h0);
        chk("t1_idle_trans", 32'(Htrans), 32'h0);
        rst_pulse();

        // Test 2: simultaneous requests, drop ignored mid-burst
        Hbusreq = 2'b11;
        tick();
        drv(0, 2'b10, 32'h100, 1'b0, 32'h0);
        #1;
        chk("t2_first", 32'(Hgrant), 32'h1);
        chk("t2_master0", 32'(Hmaster), 32'h0);
        tick();
        drv(0, 2'b11, 32'h104, 1'b0, 32'h0);
        Hbusreq = 2'b10;
        #1;
        chk("t2_hold_a", 32'(Hgrant), 32'h1);
        tick();
        drv(0, 2'b00, 32'h0, 1'b0, 32'h0);
        #1;
        chk("t2_seq_ignore", 32'(Hgrant), 32'h1);
        tick();
        drv(1, 2'b10, 32'h200, 1'b0, 32'h0);
        #1;
        chk("t2_handover", 32'(Hgrant), 32'h2);
        chk("t2_master1", 32'(Hmaster), 32'h1);
        chk("t2_addr", Haddr, 32'h200);
        chk("t2_trans", 32'(Htrans), 32'h2);
        tick();
        Hbusreq = 2'b00;
        drv(1, 2'b00, 32'h0, 1'b0, 32'h0);
        tick();
        chk("t2_idle", 32'(Hgrant), 32'h0);
        rst_pulse();

        // Test 3: beat budget forces handover
        Hbusreq = 2'b11;
        tick();
        for (int k = 0; k < 5; k++) begin
            drv(0, 2'b10, 32'h300 + 32'(4*k), 1'b1, 32'(k));
            #1;
            chk("t3_keep", 32'(Hgrant), 32'h1);
            tick();
        end
        drv(0, 2'b10, 32'h314, 1'b1, 32'hAAAA);
        drv(1, 2'b10, 32'h400, 1'b1, 32'hBBBB);
        #1;
        chk("t3_switch", 32'(Hgrant), 32'h2);
        chk("t3_noidle", 32'(Htrans), 32'h2);
        chk("t3_addr", Haddr, 32'h400);
        chk("t3_wdata_old", Hwdata, 32'hAAAA);
        tick();
        Hbusreq = 2'b00;
        drv(1, 2'b00, 32'h0, 1'b0, 32'h0);
        tick();
        rst_pulse();

        // Test 4: wait states freeze the tenure
        Hbusreq = 2'b11;
        tick();
        drv(0, 2'b10, 32'h500, 1'b1, 32'h0);
        tick();
        drv(0, 2'b11, 32'h504, 1'b1, 32'h0);
        Hreadyout = 1'b0;
        #1;
        chk("t4_readyin", 32'(Hreadyin), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_wait_grant", 32'(Hgrant), 32'h1);
            chk("t4_wait_addr", Haddr, 32'h504);
        end
        Hreadyout = 1'b1;
        tick();
        drv(0, 2'b11, 32'h508, 1'b1, 32'h0);
        tick();
        drv(0, 2'b10, 32'h600, 1'b1, 32'h0);
        tick();
        chk("t4_no_preempt", 32'(Hgrant), 32'h1);
        drv(0, 2'b00, 32'h0, 1'b0, 32'h0);
        tick();
        chk("t4_budget_hit", 32'(Hgrant), 32'h2);
        rst_pulse();

        // Test 5: async reset during SEQ beat 2
        Hbusreq = 2'b01;
        tick();
        drv(0, 2'b10, 32'h700, 1'b1, 32'h0);
        tick();
        drv(0, 2'b11, 32'h704, 1'b1, 32'h11);
        tick();
        drv(0, 2'b11, 32'h708, 1'b1, 32'h22);
        #1;
        chk("t5_pre", 32'(Hgrant), 32'h1);
        Hresetn = 1'b0;
        #1;
        chk("t5_grant", 32'(Hgrant), 32'h0);
        chk("t5_trans", 32'(Htrans), 32'h0);
        chk("t5_addr", Haddr, 32'h0);
        chk("t5_wdata", Hwdata, 32'h0);
        rst_pulse();

`ifdef AHB_ARB_LOCK_EN
        // Locked tenure ignores the beat budget
        Hbusreq = 2'b10;
        tick();
        drv(1, 2'b10, 32'h800, 1'b0, 32'h0);
        Hlock   = 2'b10;
        Hbusreq = 2'b11;
        #1;
        chk("lk_grant", 32'(Hgrant), 32'h2);
        for (int k = 0; k < 12; k++) begin
            tick();
            drv(1, 2'b10, 32'h804 + 32'(4*k), 1'b0, 32'h0);
            #1;
            chk("lk_hold", 32'(Hgrant), 32'h2);
        end
        Hlock = 2'b00;
        tick();
        drv(0, 2'b10, 32'h900, 1'b0, 32'h0);
        #1;
        chk("lk_release", 32'(Hgrant), 32'h1);
        rst_pulse();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
